fetch_prefetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the pipelined RV32I core, replacing the single-cycle pc_reg / pc_mux / instr_mem fetch path. It issues in-order requests to an instruction memory with a valid/ready request handshake and variable response latency, buffers returned instructions in a DEPTH-entry prefetch queue, and presents them to the F/D pipeline register with valid/ready. It supports a sticky run trigger, execute-stage redirects (branch/JAL/JALR) and squashing of in-flight responses.

---
 rtl/fetch_prefetch_unit.sv | 124 ++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: credit-limited in-order imem requests feeding a
// DEPTH-entry prefetch queue, with execute-stage redirect and response squashing.
module fetch_prefetch_unit #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       trigger_i,
  input  logic                       redirect_i,
  input  logic [DATA_WIDTH-1:0]      redirect_pc_i,
  output logic                       imem_req_o,
  output logic [DATA_WIDTH-1:0]      imem_addr_o,
  input  logic                       imem_ready_i,
  input  logic                       imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]      imem_rdata_i,
  output logic                       instr_valid_o,
  output logic [DATA_WIDTH-1:0]      instr_o,
  output logic [DATA_WIDTH-1:0]      pc_o,
  output logic [DATA_WIDTH-1:0]      pc_plus_4_o,
  input  logic                       instr_ready_i,
  output logic                       running_o,
  output logic [$clog2(DEPTH):0]     occupancy_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthLim = DEPTH[CntW:0];

  logic                  running_q;
  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [CntW-1:0]       outstanding_q, outstanding_d;
  logic [CntW-1:0]       drop_cnt_q, drop_cnt_d;
  logic [CntW-1:0]       occ_q, occ_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] pc_mem    [DEPTH];

  logic [CntW:0]         credit_used;
  logic                  accept, drop_resp, push, pop;
  logic [DATA_WIDTH-1:0] target;
  logic                  unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc_i[1:0];
  assign target        = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};

  // In-flight plus buffered fetches never exceed DEPTH, so responses always fit.
  assign credit_used = {1'b0, outstanding_q} + {1'b0, occ_q};
  assign imem_req_o  = running_q & ~redirect_i & (credit_used < DepthLim);
  assign imem_addr_o = fetch_pc_q;

  assign accept    = imem_req_o & imem_ready_i;
  assign drop_resp = imem_rvalid_i & (drop_cnt_q != '0);
  assign push      = imem_rvalid_i & (drop_cnt_q == '0) & ~redirect_i;
  assign pop       = instr_valid_o & instr_ready_i & ~redirect_i;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    occ_d         = occ_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    outstanding_d = outstanding_q + CntW'(accept) - CntW'(imem_rvalid_i);
    if (redirect_i) begin
      fetch_pc_d = target;
      resp_pc_d  = target;
      occ_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      // Every fetch still in flight after this cycle is squashed.
      drop_cnt_d = outstanding_q - CntW'(imem_rvalid_i);
    end else begin
      if (accept)    fetch_pc_d = fetch_pc_q + DATA_WIDTH'(4);
      if (drop_resp) drop_cnt_d = drop_cnt_q - CntW'(1);
      if (push) begin
        resp_pc_d = resp_pc_q + DATA_WIDTH'(4);
        wr_ptr_d  = wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
      occ_d = occ_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running_q     <= 1'b0;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      occ_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      running_q     <= running_q | trigger_i;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      occ_q         <= occ_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= imem_rdata_i;
      pc_mem[wr_ptr_q]    <= resp_pc_q;
    end
  end

  assign running_o     = running_q;
  assign occupancy_o   = occ_q;
  assign instr_valid_o = (occ_q != '0);
  assign instr_o       = instr_valid_o ? instr_mem[rd_ptr_q] : '0;
  assign pc_o          = instr_valid_o ? pc_mem[rd_ptr_q] : '0;
  assign pc_plus_4_o   = instr_valid_o ? pc_mem[rd_ptr_q] + DATA_WIDTH'(4) : '0;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Randomized bench for fetch_prefetch_unit: an in-order variable-latency memory
// plus a queue-based reference of the fetch stream checked every cycle.
module tb_fetch_prefetch_unit;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trigger_i = 1'b0, redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o, imem_ready_i = 1'b0, imem_rvalid_i = 1'b0;
  logic [31:0] imem_addr_o, imem_rdata_i = '0;
  logic        instr_valid_o, instr_ready_i = 1'b0, running_o;
  logic [31:0] instr_o, pc_o, pc_plus_4_o;
  logic [2:0]  occupancy_o;

  fetch_prefetch_unit #(.DATA_WIDTH(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .trigger_i(trigger_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ready_i(imem_ready_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .pc_o(pc_o), .pc_plus_4_o(pc_plus_4_o),
    .instr_ready_i(instr_ready_i), .running_o(running_o), .occupancy_o(occupancy_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int cyc = 0;

  // Memory model: accepted addresses with the cycle their response is due.
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  int          last_due = 0;
  int          lat_min = 1, lat_max = 1;

  // Reference model: fetch stream as queues of in-flight and buffered fetches.
  bit          m_running;
  logic [31:0] m_fetch_pc;
  logic [31:0] m_inf_addr[$];
  bit          m_inf_keep[$];
  logic [31:0] m_buf_pc[$], m_buf_instr[$];

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_running = 1'b0;
    m_fetch_pc = RESET_PC;
    m_inf_addr.delete(); m_inf_keep.delete();
    m_buf_pc.delete(); m_buf_instr.delete();
    mem_addr_q.delete(); mem_due_q.delete();
    last_due = cyc;
  endtask

  function automatic bit resp_due_now();
    return mem_addr_q.size() > 0 && mem_due_q[0] <= cyc;
  endfunction

  task automatic step(input bit trig, input bit redir, input logic [31:0] rpc,
                      input bit rdy, input bit irdy);
    bit          rv, exp_req, exp_valid, pop, k;
    logic [31:0] rd, a;
    int          lat, due;
    @(negedge clk);
    rv = resp_due_now();
    rd = rv ? mem_data(mem_addr_q[0]) : 32'h0;
    trigger_i = trig; redirect_i = redir; redirect_pc_i = rpc;
    imem_ready_i = rdy; instr_ready_i = irdy;
    imem_rvalid_i = rv; imem_rdata_i = rv ? rd : $urandom;
    #1;
    exp_req = m_running && !redir && (m_inf_addr.size() + m_buf_pc.size() < DEPTH);
    exp_valid = m_buf_pc.size() > 0;
    check_eq("running", 32'(running_o), 32'(m_running));
    check_eq("req", 32'(imem_req_o), 32'(exp_req));
    check_eq("addr", imem_addr_o, m_fetch_pc);
    check_eq("valid", 32'(instr_valid_o), 32'(exp_valid));
    check_eq("occupancy", 32'(occupancy_o), m_buf_pc.size());
    check_eq("pc", pc_o, exp_valid ? m_buf_pc[0] : 32'h0);
    check_eq("instr", instr_o, exp_valid ? m_buf_instr[0] : 32'h0);
    check_eq("pc_plus_4", pc_plus_4_o, exp_valid ? m_buf_pc[0] + 32'd4 : 32'h0);
    pop = exp_valid && irdy;
    k = 1'b0; a = '0;
    if (rv) begin
      void'(mem_addr_q.pop_front()); void'(mem_due_q.pop_front());
      if (m_inf_addr.size() == 0) check_eq("spurious_resp", 32'd1, 32'd0);
      else begin a = m_inf_addr.pop_front(); k = m_inf_keep.pop_front(); end
    end
    if (redir) begin
      m_buf_pc.delete(); m_buf_instr.delete();
      foreach (m_inf_keep[i]) m_inf_keep[i] = 1'b0;
      m_fetch_pc = {rpc[31:2], 2'b00};
    end else begin
      if (pop) begin void'(m_buf_pc.pop_front()); void'(m_buf_instr.pop_front()); end
      if (rv && k) begin m_buf_pc.push_back(a); m_buf_instr.push_back(rd); end
      if (exp_req && rdy) begin
        m_inf_addr.push_back(m_fetch_pc); m_inf_keep.push_back(1'b1);
        lat = $urandom_range(lat_max, lat_min);
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mem_addr_q.push_back(m_fetch_pc); mem_due_q.push_back(due);
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
    if (trig) m_running = 1'b1;
    @(posedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    trigger_i = 0; redirect_i = 0; redirect_pc_i = '0; imem_ready_i = 0;
    imem_rvalid_i = 0; imem_rdata_i = '0; instr_ready_i = 0;
    rst_n = 1'b0;
    #1;
    check_eq("rst_running", 32'(running_o), 32'd0);
    check_eq("rst_req", 32'(imem_req_o), 32'd0);
    check_eq("rst_addr", imem_addr_o, RESET_PC);
    check_eq("rst_valid", 32'(instr_valid_o), 32'd0);
    check_eq("rst_instr", instr_o, 32'h0);
    check_eq("rst_pc", pc_o, 32'h0);
    check_eq("rst_pc4", pc_plus_4_o, 32'h0);
    check_eq("rst_occ", 32'(occupancy_o), 32'd0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    bit done;
    do_reset();

    // Zero-wait memory streaming.
    lat_min = 1; lat_max = 1;
    step(1, 0, '0, 1, 1);
    repeat (30) step(0, 0, '0, 1, 1);

    // Decode stall: queue fills to DEPTH and requests stop.
    repeat (12) step(0, 0, '0, 1, 0);
    check_eq("occ_saturated", 32'(occupancy_o), DEPTH);
    repeat (10) step(0, 0, '0, 1, 1);

    // Three-cycle memory, then redirect to 0x103 with three fetches in flight.
    lat_min = 3; lat_max = 3;
    repeat (20) step(0, 0, '0, 1, 1);
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (m_inf_addr.size() == 3) begin
        step(0, 1, 32'h0000_0103, 1, 1);
        done = 1;
      end else step(0, 0, '0, 1, 1);
    end
    check_eq("redirect_hit", 32'(done), 32'd1);
    repeat (20) step(0, 0, '0, 1, 1);

    // Redirect coinciding with a response and a pop.
    lat_min = 1; lat_max = 2;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (resp_due_now() && m_buf_pc.size() > 0) begin
        step(0, 1, 32'h0000_2000, 1, 1);
        done = 1;
      end else step(0, 0, '0, 1, ($urandom_range(3, 0) != 0));
    end
    check_eq("redir_rvalid_hit", 32'(done), 32'd1);
    step(0, 0, '0, 1, 1);

    // Random traffic.
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(49, 0) == 0), ($urandom_range(24, 0) == 0), $urandom,
           ($urandom_range(3, 0) != 0), ($urandom_range(9, 0) < 7));

    // Mid-stream reset: idle until a fresh trigger, early redirect moves target.
    do_reset();
    repeat (4) step(0, 0, '0, 1, 1);
    step(0, 1, 32'h0000_0456, 1, 1);
    repeat (3) step(0, 0, '0, 1, 1);
    step(1, 0, '0, 1, 1);
    for (int i = 0; i < 300; i++)
      step(0, ($urandom_range(29, 0) == 0), $urandom,
           ($urandom_range(3, 0) != 0), ($urandom_range(9, 0) < 7));

    do_reset();
    step(1, 0, '0, 1, 1);
    repeat (10) step(0, 0, '0, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
